// File: rtl/regfile_pkg.sv
// Shared types and limits for the multi-port register file.
// The clear-sequencer state encoding lives here so the top and the FSM agree on it.
package regfile_pkg;

  typedef enum logic [1:0] {CLR_IDLE, CLR_SWEEP, CLR_DONE} clr_state_t;

  localparam int REGFILE_MAX_WIDTH = 32;
  localparam int REGFILE_MAX_DEPTH = 64;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: walks every entry index once, one per cycle, then pulses done.
// Owns the sweep state and index; the top level applies clr_we/clr_idx to the array.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  clr_state_t    state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLR_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Stopping on LAST_IDX rather than on wrap keeps non-power-of-two depths in range.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      CLR_IDLE: begin
        if (clr_req) begin
          state_nxt = CLR_SWEEP;
          idx_nxt   = '0;
        end
      end
      CLR_SWEEP: begin
        if (idx == LAST_IDX) state_nxt = CLR_DONE;
        else                 idx_nxt   = idx + AW'(1);
      end
      CLR_DONE:  state_nxt = CLR_IDLE;
      default:   state_nxt = CLR_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == CLR_SWEEP);
    clr_we   = (state == CLR_SWEEP);
    clr_done = (state == CLR_DONE);
    clr_idx  = idx;
  end

endmodule

// File: rtl/regfile_multi.sv
// Parametrised register file: one write port, two registered read ports, hardware clear sweep.
// Define REGFILE_BYPASS_EN to forward an accepted same-cycle write to a matching read port.
module regfile_multi
  import regfile_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr0,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data0,
  output logic [WIDTH-1:0] rd_data1,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_done
);

  if (WIDTH < 1 || WIDTH > REGFILE_MAX_WIDTH) begin : g_bad_width
    $error("regfile_multi: WIDTH out of range");
  end
  if (DEPTH < 2 || DEPTH > REGFILE_MAX_DEPTH) begin : g_bad_depth
    $error("regfile_multi: DEPTH out of range");
  end

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             clr_we;
  logic [AW-1:0]    clr_idx;
  logic             wr_ok, rd_ok0, rd_ok1;
  logic [WIDTH-1:0] rd_nxt0, rd_nxt1;

  regfile_clr_fsm #(.DEPTH(DEPTH)) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx)
  );

  // User writes are refused outright while sweeping, so the two array writers never overlap.
  always_comb begin
    wr_ok  = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_W);
    rd_ok0 = ({1'b0, rd_addr0} < DEPTH_W);
    rd_ok1 = ({1'b0, rd_addr1} < DEPTH_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_nxt0 = rd_ok0 ? mem[rd_addr0] : '0;
    rd_nxt1 = rd_ok1 ? mem[rd_addr1] : '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (rd_addr0 == wr_addr)) rd_nxt0 = wr_data;
    if (wr_ok && (rd_addr1 == wr_addr)) rd_nxt1 = wr_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data0 <= '0;
      rd_data1 <= '0;
    end else begin
      rd_data0 <= rd_nxt0;
      rd_data1 <= rd_nxt1;
    end
  end

endmodule
